seg7_writer: RTL and testbench

Memory-mapped 8-digit seven-segment display writer on the CPU output side of the MMIO bus. It is the output counterpart to the switch reader. CPU store instructions write a 32-bit hex value, a digit-enable mask and a decimal-point mask through a 2-bit halfword address. The block time-multiplexes the 8 digits using a divided scan clock and drives active-low anode and segment lines.

---
 rtl/seg_pkg.sv | 39 +++
 rtl/hex_to_seg7.sv | 17 +
 rtl/seg7_writer.sv | 143 ++++++++++++++
 tb/tb_seg7_writer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg -- shared constants for the seven-segment display writer.
//
// Contents:
//   SEG_ADDR_*  halfword register addresses on the MMIO output bus
//   SEG_BLANK   active-low "all off" pattern for anodes and segments
//   SEG_GLYPH   16-entry hex glyph table, active-high gfedcba
//               (entry 0 is the rightmost 7-bit field; lowercase b and d)
// ---------------------------------------------------------------------------
package seg_pkg;

  localparam logic [1:0] SEG_ADDR_LO    = 2'b00;
  localparam logic [1:0] SEG_ADDR_MASK  = 2'b01;
  localparam logic [1:0] SEG_ADDR_HI    = 2'b10;
  localparam logic [1:0] SEG_ADDR_BLINK = 2'b11;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Packed so that SEG_GLYPH[n] selects the glyph for nibble n.
  localparam logic [15:0][6:0] SEG_GLYPH = {
    7'h71,  // F
    7'h79,  // E
    7'h5E,  // d
    7'h39,  // C
    7'h7C,  // b
    7'h77,  // A
    7'h6F,  // 9
    7'h7F,  // 8
    7'h07,  // 7
    7'h7D,  // 6
    7'h6D,  // 5
    7'h66,  // 4
    7'h4F,  // 3
    7'h5B,  // 2
    7'h06,  // 1
    7'h3F   // 0
  };

endpackage

// File: rtl/hex_to_seg7.sv
// ---------------------------------------------------------------------------
// hex_to_seg7 -- combinational hex nibble to seven-segment glyph decoder.
//
// Ports:
//   nibble  in   4  hex digit 0..F
//   seg     out  7  segments, active-high, bit order g,f,e,d,c,b,a
// ---------------------------------------------------------------------------
module hex_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_GLYPH[nibble];

endmodule

// File: rtl/seg7_writer.sv
// ---------------------------------------------------------------------------
// seg7_writer -- memory-mapped 8-digit seven-segment display writer.
//
// The CPU stores a 32-bit hex value, a digit-enable mask and a decimal-point
// mask through a 2-bit halfword address. The block scans one digit per
// SCAN_DIV clocks and drives active-low anodes and segments, registered on
// the falling edge of segclk.
//
// Optional feature (macro SEG_BLINK_EN): per-digit blink mask at address 11;
// a digit whose mask bit is set is blanked while the MSB of a free-running
// BLINK_BITS-wide counter is 1.
//
// Ports:
//   segclk     in   1   system clock, all state on the falling edge
//   switchrst  in   1   reset, asynchronous, active-high
//   segctl     in   1   chip select from the MMIO address decode
//   segwrite   in   1   store strobe
//   segaddr    in   2   00 value[15:0], 10 value[31:16],
//                       01 {dp_mask, en_mask}, 11 blink_mask[7:0]
//   segwdata   in   16  write data
//   seg_an     out  8   digit anodes, active-low, digit 0 rightmost
//   seg_out    out  8   segments, active-low, bit7 dp, bits6..0 g..a
// ---------------------------------------------------------------------------
module seg7_writer
  import seg_pkg::*;
#(
  parameter logic [15:0] SCAN_DIV   = 16'd50000,
  parameter int          BLINK_BITS = 24
) (
  input  logic        segclk,
  input  logic        switchrst,
  input  logic        segctl,
  input  logic        segwrite,
  input  logic [1:0]  segaddr,
  input  logic [15:0] segwdata,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_out
);

  logic [31:0] value;
  logic [7:0]  en_mask;
  logic [7:0]  dp_mask;
  logic [15:0] div_cnt;
  logic [2:0]  idx;

  logic        wr_en;
  logic        lit;
  logic [6:0]  glyph;
  logic [7:0]  an_next;
  logic [7:0]  out_next;

  assign wr_en = segctl && segwrite;

`ifdef SEG_BLINK_EN
  logic [7:0]            blink_mask;
  logic [BLINK_BITS-1:0] blink_cnt;

  always_ff @(negedge segclk or posedge switchrst) begin
    if (switchrst) begin
      blink_mask <= '0;
      blink_cnt  <= '0;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
      if (wr_en && segaddr == SEG_ADDR_BLINK) begin
        blink_mask <= segwdata[7:0];
      end
    end
  end
`else
  // Keeps the parameter list identical in both builds.
  logic [BLINK_BITS-1:0] unused_blink;
  assign unused_blink = '0;
`endif

  // Register file and scan divider.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; a write and a scan tick on the same edge
  // therefore both take effect independently.
  always_ff @(negedge segclk or posedge switchrst) begin
    if (switchrst) begin
      value   <= '0;
      en_mask <= 8'hFF;
      dp_mask <= '0;
      div_cnt <= '0;
      idx     <= '0;
    end else begin
      if (wr_en) begin
        case (segaddr)
          SEG_ADDR_LO:   value[15:0]  <= segwdata;
          SEG_ADDR_HI:   value[31:16] <= segwdata;
          SEG_ADDR_MASK: begin
            en_mask <= segwdata[7:0];
            dp_mask <= segwdata[15:8];
          end
          default: ;  // blink mask lives in its own block
        endcase
      end

      if (div_cnt == SCAN_DIV - 16'd1) begin
        div_cnt <= '0;
        idx     <= idx + 3'd1;
      end else begin
        div_cnt <= div_cnt + 16'd1;
      end
    end
  end

  // Single decoder shared by all digits, fed by the nibble under the scan.
  hex_to_seg7 u_hex (
    .nibble (value[{idx, 2'b00} +: 4]),
    .seg    (glyph)
  );

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    lit      = en_mask[idx];
`ifdef SEG_BLINK_EN
    if (blink_cnt[BLINK_BITS-1] && blink_mask[idx]) begin
      lit = 1'b0;
    end
`endif
    an_next  = SEG_BLANK;
    out_next = SEG_BLANK;
    if (lit) begin
      an_next[idx] = 1'b0;
      out_next     = ~{dp_mask[idx], glyph};
    end
  end

  // NOTE: outputs are reset too, so the display is dark the moment reset
  // asserts rather than one edge later.
  always_ff @(negedge segclk or posedge switchrst) begin
    if (switchrst) begin
      seg_an  <= SEG_BLANK;
      seg_out <= SEG_BLANK;
    end else begin
      seg_an  <= an_next;
      seg_out <= out_next;
    end
  end

endmodule

// File: tb/tb_seg7_writer.sv
// ---------------------------------------------------------------------------
// tb_seg7_writer -- self-checking bench for seg7_writer (SCAN_DIV=4,
// BLINK_BITS=4). A reference model tracks the register contents and the
// number of falling edges since reset; the displayed digit and blink phase
// are derived arithmetically from that count.
// ---------------------------------------------------------------------------
module tb_seg7_writer;

  localparam int SD = 4;
  localparam int BB = 4;

  logic        segclk    = 1'b0;
  logic        switchrst = 1'b1;
  logic        segctl    = 1'b0;
  logic        segwrite  = 1'b0;
  logic [1:0]  segaddr   = 2'b00;
  logic [15:0] segwdata  = 16'h0000;
  logic [7:0]  seg_an;
  logic [7:0]  seg_out;

  seg7_writer #(
    .SCAN_DIV   (16'(SD)),
    .BLINK_BITS (BB)
  ) dut (
    .segclk    (segclk),
    .switchrst (switchrst),
    .segctl    (segctl),
    .segwrite  (segwrite),
    .segaddr   (segaddr),
    .segwdata  (segwdata),
    .seg_an    (seg_an),
    .seg_out   (seg_out)
  );

  always #5 segclk = ~segclk;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [31:0] m_value;
  logic [7:0]  m_en;
  logic [7:0]  m_dp;
  logic [7:0]  m_blink;
  int          m_cnt;
  int          shown_idx;

  typedef struct {
    bit          wr;
    logic [1:0]  addr;
    logic [15:0] data;
    int          digit;
    logic [7:0]  an;
    logic [7:0]  out;
  } vec_t;

  vec_t vecs [9];

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'b0111111;  4'h1: glyph = 7'b0000110;
      4'h2: glyph = 7'b1011011;  4'h3: glyph = 7'b1001111;
      4'h4: glyph = 7'b1100110;  4'h5: glyph = 7'b1101101;
      4'h6: glyph = 7'b1111101;  4'h7: glyph = 7'b0000111;
      4'h8: glyph = 7'b1111111;  4'h9: glyph = 7'b1101111;
      4'hA: glyph = 7'b1110111;  4'hB: glyph = 7'b1111100;
      4'hC: glyph = 7'b0111001;  4'hD: glyph = 7'b1011110;
      4'hE: glyph = 7'b1111001;  default: glyph = 7'b1110001;
    endcase
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_value   = '0;
    m_en      = 8'hFF;
    m_dp      = '0;
    m_blink   = '0;
    m_cnt     = 0;
    shown_idx = 0;
  endtask

  // One falling edge: drive inputs mid-cycle, compare the outputs that edge
  // produced against the model, then apply the write to the model.
  task automatic tick(input logic ctl, input logic wr, input logic [1:0] addr,
                      input logic [15:0] data, input string tag);
    int         d;
    logic       blank;
    logic [7:0] ea;
    logic [7:0] eo;
    @(posedge segclk);
    segctl   = ctl;
    segwrite = wr;
    segaddr  = addr;
    segwdata = data;
    @(negedge segclk);
    #1;
    d     = (m_cnt / SD) % 8;
    blank = !m_en[d];
`ifdef SEG_BLINK_EN
    if (m_blink[d] && ((m_cnt >> (BB - 1)) % 2 == 1)) blank = 1'b1;
`endif
    ea = blank ? 8'hFF : ~(8'h01 << d);
    eo = blank ? 8'hFF : ~{m_dp[d], glyph(m_value[4*d +: 4])};
    check({tag, "_an"}, seg_an, ea);
    check({tag, "_out"}, seg_out, eo);
    shown_idx = d;
    if (ctl && wr) begin
      case (addr)
        2'b00: m_value[15:0]  = data;
        2'b10: m_value[31:16] = data;
        2'b01: begin m_en = data[7:0]; m_dp = data[15:8]; end
        default: begin
`ifdef SEG_BLINK_EN
          m_blink = data[7:0];
`endif
        end
      endcase
    end
    m_cnt++;
  endtask

  task automatic idle(input string tag);
    tick(1'b0, 1'b0, 2'b00, 16'h0000, tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 2'b00, 16'h1234, 0, 8'hFE, 8'h99};  // "4"
    vecs[1] = '{1'b1, 2'b10, 16'hABCD, 7, 8'h7F, 8'h88};  // "A"
    vecs[2] = '{1'b0, 2'b00, 16'h0000, 4, 8'hEF, 8'hA1};  // "d"
    vecs[3] = '{1'b1, 2'b01, 16'h01F0, 0, 8'hFF, 8'hFF};  // digit 0 off
    vecs[4] = '{1'b0, 2'b00, 16'h0000, 4, 8'hEF, 8'hA1};  // "d", dp clear
    vecs[5] = '{1'b1, 2'b01, 16'h0101, 0, 8'hFE, 8'h19};  // "4." dp lit
    vecs[6] = '{1'b1, 2'b01, 16'h00FF, 1, 8'hFD, 8'hB0};  // "3"
    vecs[7] = '{1'b0, 2'b00, 16'h0000, 5, 8'hDF, 8'hC6};  // "C"
    vecs[8] = '{1'b1, 2'b11, 16'h0001, 2, 8'hFB, 8'hA4};  // "2"

    // Power-on reset.
    model_reset();
    repeat (3) @(negedge segclk);
    #1;
    check("por_an", seg_an, 8'hFF);
    check("por_out", seg_out, 8'hFF);
    #1 switchrst = 1'b0;

    // Table-driven vectors: write, then wait for the target digit's slot.
    for (int v = 0; v < 9; v++) begin
      int guard;
      if (vecs[v].wr) tick(1'b1, 1'b1, vecs[v].addr, vecs[v].data, "vec_wr");
      idle("vec_idle");
      guard = 0;
      while (shown_idx != vecs[v].digit && guard < 64) begin
        idle("vec_wait");
        guard++;
      end
      if (guard >= 64) begin
        total++;
        bad++;
        $display("FAIL vec%0d_timeout: got digit %0d expected digit %0d", v, shown_idx, vecs[v].digit);
      end
      check($sformatf("vec%0d_an", v), seg_an, vecs[v].an);
      check($sformatf("vec%0d_out", v), seg_out, vecs[v].out);
    end

    // Randomised traffic against the model.
    for (int i = 0; i < 300; i++) begin
      tick(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
           2'($urandom), 16'($urandom), "rand");
    end

    // Reset mid-run with a write in flight.
    tick(1'b1, 1'b1, 2'b01, 16'h00FF, "relight");
    #2;
    segctl   = 1'b1;
    segwrite = 1'b1;
    segaddr  = 2'b00;
    segwdata = 16'hFFFF;
    switchrst = 1'b1;
    #1;
    check("midrst_an", seg_an, 8'hFF);
    check("midrst_out", seg_out, 8'hFF);
    @(negedge segclk);
    #2;
    segctl    = 1'b0;
    segwrite  = 1'b0;
    switchrst = 1'b0;
    model_reset();

    // Scan walk after release: four edges per digit, value 0 shown.
    for (int k = 0; k < 12; k++) begin
      idle("walk");
      check("walk_an", seg_an, ~(8'h01 << (k / SD)));
      check("walk_out", seg_out, 8'hC0);
    end

    // Write landing on the scan-tick edge (edge count 15 -> idx becomes 4).
    repeat (3) idle("pre_tick");
    tick(1'b1, 1'b1, 2'b10, 16'h0005, "tick_wr");
    idle("after_tick");
    check("tickwr_an", seg_an, 8'hEF);
    check("tickwr_out", seg_out, 8'h92);

    // Write to the digit currently on display: visible on the next edge.
    tick(1'b1, 1'b1, 2'b10, 16'h0007, "cur_wr");
    check("curwr_old_out", seg_out, 8'h92);
    idle("cur_after");
    check("curwr_an", seg_an, 8'hEF);
    check("curwr_out", seg_out, 8'hF8);

    // Blocked writes at every address across a full sweep.
    for (int i = 0; i < 8 * SD + 4; i++) begin
      if (i % 2 == 0) tick(1'b0, 1'b1, 2'(i % 4), 16'($urandom), "no_ctl");
      else            tick(1'b1, 1'b0, 2'(i % 4), 16'($urandom), "no_wr");
    end

    // Blink mask on digit 0 (no effect unless the feature is built in).
    tick(1'b1, 1'b1, 2'b01, 16'h00FF, "blink_en");
    tick(1'b1, 1'b1, 2'b11, 16'h0001, "blink_wr");
    repeat (80) idle("blink");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
